// File: rtl/ser_pkg.sv
// Shared definitions for the bit-serial register link receiver.
package ser_pkg;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  // Data bits plus parity bit must XOR to this value.
  localparam logic PARITY_SENSE = 1'b1;

  function automatic logic parity_bad(input logic xor_all);
    return xor_all != PARITY_SENSE;
  endfunction

endpackage

// File: rtl/sync_nff.sv
// Width x depth flop chain used to bring asynchronous inputs into the clk domain.
module sync_nff #(
  parameter int           W       = 1,
  parameter int           D       = 2,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [D*W-1:0] chain_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_reg <= {D{RST_VAL}};
    end else if (D > 1) begin
      chain_reg <= {chain_reg[(D-1)*W-1:0], d};
    end else begin
      chain_reg <= d;
    end
  end

  assign q = chain_reg[D*W-1 -: W];

endmodule

// File: rtl/ser_word_rx.sv
// Bit-serial word receiver: synchronizes strobe/select/data and assembles MSB-first words.
// Optional odd parity bit per word when SER_WORD_RX_PARITY_EN is defined.
module ser_word_rx
  import ser_pkg::*;
#(
  parameter int   P_NBITS  = 8,
  parameter int   P_NSYNC  = 2,
  parameter logic P_DEFVAL = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ser_clk,
  input  logic               ser_cs_n,
  input  logic               ser_dat,
  output logic [P_NBITS-1:0] y,
  output logic               y_vld,
  output logic               busy,
  output logic               frm_err,
  output logic               par_err
);

  localparam int CW = $clog2(P_NBITS + 1);
`ifdef SER_WORD_RX_PARITY_EN
  localparam logic [CW-1:0] LAST_CNT = CW'(P_NBITS);
`else
  localparam logic [CW-1:0] LAST_CNT = CW'(P_NBITS - 1);
`endif

  logic [2:0] sync_q;
  logic       sclk_s, cs_s, dat_s;
  logic       sclk_d_reg;
  logic       strobe;

  // One chain for all three wires keeps them mutually aligned.
  sync_nff #(
    .W       (3),
    .D       (P_NSYNC),
    .RST_VAL (3'b110)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     ({ser_clk, ser_cs_n, ser_dat}),
    .q     (sync_q)
  );

  assign {sclk_s, cs_s, dat_s} = sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sclk_d_reg <= 1'b1;
    else        sclk_d_reg <= sclk_s;
  end

  assign strobe = sclk_s & ~sclk_d_reg;

  state_t             state_reg;
  logic [CW-1:0]      cnt_reg;
  logic [P_NBITS-1:0] shift_reg;
  logic [P_NBITS-1:0] y_reg;
  logic               y_vld_reg;
  logic               frm_err_reg;
  logic [P_NBITS-1:0] word_next;

  assign word_next = {shift_reg[P_NBITS-2:0], dat_s};

`ifdef SER_WORD_RX_PARITY_EN
  logic par_err_reg;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= S_IDLE;
      cnt_reg     <= '0;
      shift_reg   <= '0;
      y_reg       <= {P_NBITS{P_DEFVAL}};
      y_vld_reg   <= 1'b0;
      frm_err_reg <= 1'b0;
`ifdef SER_WORD_RX_PARITY_EN
      par_err_reg <= 1'b0;
`endif
    end else begin
      y_vld_reg   <= 1'b0;
      frm_err_reg <= 1'b0;
`ifdef SER_WORD_RX_PARITY_EN
      par_err_reg <= 1'b0;
`endif
      case (state_reg)
        S_IDLE: begin
          cnt_reg <= '0;
          if (!cs_s) state_reg <= S_SHIFT;
        end
        S_SHIFT: begin
          // A select release outranks a coincident strobe; that bit is dropped.
          if (cs_s) begin
            frm_err_reg <= (cnt_reg != '0);
            cnt_reg     <= '0;
            state_reg   <= S_IDLE;
          end else if (strobe) begin
            if (cnt_reg == LAST_CNT) begin
              cnt_reg   <= '0;
              y_vld_reg <= 1'b1;
`ifdef SER_WORD_RX_PARITY_EN
              y_reg       <= shift_reg;
              par_err_reg <= parity_bad(^{shift_reg, dat_s});
`else
              y_reg       <= word_next;
`endif
            end else begin
              shift_reg <= word_next;
              cnt_reg   <= cnt_reg + 1'b1;
            end
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign y       = y_reg;
  assign y_vld   = y_vld_reg;
  assign frm_err = frm_err_reg;
  assign busy    = (state_reg == S_SHIFT) && (cnt_reg != '0);
`ifdef SER_WORD_RX_PARITY_EN
  assign par_err = par_err_reg;
`else
  assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_ser_word_rx.sv
// Scoreboard bench for ser_word_rx; covers parity when SER_WORD_RX_PARITY_EN is defined.
module tb_ser_word_rx;

  localparam logic TB_DEFVAL = 1'b1;
`ifdef SER_WORD_RX_PARITY_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ser_clk = 1'b0;
  logic       ser_cs_n = 1'b1;
  logic       ser_dat = 1'b0;
  logic [7:0] y;
  logic       y_vld, busy, frm_err, par_err;

  ser_word_rx #(
    .P_NBITS  (8),
    .P_NSYNC  (2),
    .P_DEFVAL (TB_DEFVAL)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ser_clk  (ser_clk),
    .ser_cs_n (ser_cs_n),
    .ser_dat  (ser_dat),
    .y        (y),
    .y_vld    (y_vld),
    .busy     (busy),
    .frm_err  (frm_err),
    .par_err  (par_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] w;
    logic       p;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   vld_cnt = 0;
  int   frm_cnt = 0;
  logic vld_prev = 1'b0;
  logic frm_prev = 1'b0;

  // Output monitor: pops the scoreboard on every y_vld pulse.
  always @(negedge clk) begin
    exp_t e;
    if (y_vld) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_vld: got y=%02h, required no word", y);
      end else begin
        e = exp_q.pop_front();
        if (y !== e.w || par_err !== e.p) begin
          failures++;
          $display("FAIL word: got y=%02h par_err=%b, required y=%02h par_err=%b", y, par_err, e.w, e.p);
        end else begin
          $display("word y=%02h par_err=%b ok", y, par_err);
        end
      end
    end
    if ((y_vld && vld_prev) || (frm_err && frm_prev) || (par_err && !y_vld)) begin
      checks++;
      failures++;
      $display("FAIL pulse_shape: y_vld=%b/%b frm_err=%b/%b par_err=%b, required single-cycle pulses",
               vld_prev, y_vld, frm_prev, frm_err, par_err);
    end
    vld_prev = y_vld;
    frm_prev = frm_err;
    vld_cnt += int'(y_vld);
    frm_cnt += int'(frm_err);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    ser_dat = b;
    wait_clks(2);
    ser_clk = 1'b1;
    wait_clks(3);
    ser_clk = 1'b0;
    wait_clks(3);
  endtask

  // pbit is only transmitted when parity is compiled in.
  task automatic send_word(input logic [7:0] w, input logic pbit, input logic pexp);
    exp_t e;
    e.w = w;
    e.p = pexp;
    exp_q.push_back(e);
    for (int i = 7; i >= 0; i--) send_bit(w[i]);
`ifdef SER_WORD_RX_PARITY_EN
    send_bit(pbit);
`endif
  endtask

  task automatic test_reset();
    wait_clks(3);
    checks++;
    if (y !== {8{TB_DEFVAL}} || y_vld !== 1'b0 || busy !== 1'b0 || frm_err !== 1'b0 || par_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: got y=%02h vld=%b busy=%b frm=%b par=%b, required y=%02h others 0",
               y, y_vld, busy, frm_err, par_err, {8{TB_DEFVAL}});
    end
    rst_n = 1'b1;
    wait_clks(5);
    checks++;
    if (y !== {8{TB_DEFVAL}} || busy !== 1'b0) begin
      failures++;
      $display("FAIL post_reset: got y=%02h busy=%b, required y=%02h busy=0", y, busy, {8{TB_DEFVAL}});
    end
    $display("reset done");
  endtask

  task automatic test_single();
    logic [NB-1:0] bits;
    exp_t          e;
    int            v0;
    v0 = vld_cnt;
`ifdef SER_WORD_RX_PARITY_EN
    bits = {8'hA5, 1'b1};
`else
    bits = 8'hA5;
`endif
    ser_cs_n = 1'b0;
    wait_clks(4);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL busy_before: got %b, required 0", busy);
    end
    for (int i = NB - 1; i >= 1; i--) begin
      send_bit(bits[i]);
      checks++;
      if (busy !== 1'b1) begin
        failures++;
        $display("FAIL busy_bit%0d: got %b, required 1", NB - i, busy);
      end
    end
    e.w = 8'hA5;
    e.p = 1'b0;
    exp_q.push_back(e);
    @(negedge clk);
    ser_dat = bits[0];
    wait_clks(2);
    ser_clk = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (y_vld !== 1'b0) begin
      failures++;
      $display("FAIL latency_early: got y_vld=%b after edge k+1, required 0", y_vld);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (y_vld !== 1'b1 || y !== 8'hA5) begin
      failures++;
      $display("FAIL latency_k2: got y_vld=%b y=%02h, required 1 / a5", y_vld, y);
    end
    @(negedge clk);
    checks++;
    if (y_vld !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL after_word: got y_vld=%b busy=%b, required 0 / 0", y_vld, busy);
    end
    wait_clks(1);
    ser_clk = 1'b0;
    wait_clks(3);
    checks++;
    if (vld_cnt - v0 !== 1) begin
      failures++;
      $display("FAIL single_vld_count: got %0d, required 1", vld_cnt - v0);
    end
  endtask

  task automatic test_back_to_back();
    int v0, f0;
    v0 = vld_cnt;
    f0 = frm_cnt;
    send_word(8'h3C, ~^8'h3C, 1'b0);
    send_word(8'hC3, ~^8'hC3, 1'b0);
    ser_cs_n = 1'b1;
    wait_clks(6);
    checks++;
    if (vld_cnt - v0 !== 2 || frm_cnt - f0 !== 0 || y !== 8'hC3) begin
      failures++;
      $display("FAIL back_to_back: got vld=%0d frm=%0d y=%02h, required 2 / 0 / c3", vld_cnt - v0, frm_cnt - f0, y);
    end
  endtask

  task automatic test_frame_err();
    int v0, f0;
    v0 = vld_cnt;
    f0 = frm_cnt;
    ser_cs_n = 1'b0;
    wait_clks(4);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    ser_cs_n = 1'b1;
    wait_clks(6);
    checks++;
    if (frm_cnt - f0 !== 1 || vld_cnt - v0 !== 0 || y !== 8'hC3 || busy !== 1'b0) begin
      failures++;
      $display("FAIL frame_err: got frm=%0d vld=%0d y=%02h busy=%b, required 1 / 0 / c3 / 0",
               frm_cnt - f0, vld_cnt - v0, y, busy);
    end
    ser_cs_n = 1'b0;
    wait_clks(4);
    send_word(8'h5A, ~^8'h5A, 1'b0);
    ser_cs_n = 1'b1;
    wait_clks(6);
    checks++;
    if (vld_cnt - v0 !== 1 || frm_cnt - f0 !== 1) begin
      failures++;
      $display("FAIL after_frame_err: got vld=%0d frm=%0d, required 1 / 1", vld_cnt - v0, frm_cnt - f0);
    end
  endtask

  task automatic test_reset_mid();
    int v0, f0;
    ser_cs_n = 1'b0;
    wait_clks(4);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    f0 = frm_cnt;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (y !== {8{TB_DEFVAL}} || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid: got y=%02h busy=%b, required y=%02h busy=0", y, busy, {8{TB_DEFVAL}});
    end
    wait_clks(3);
    rst_n = 1'b1;
    wait_clks(5);
    v0 = vld_cnt;
    send_word(8'h81, ~^8'h81, 1'b0);
    ser_cs_n = 1'b1;
    wait_clks(6);
    checks++;
    if (vld_cnt - v0 !== 1 || frm_cnt - f0 !== 0 || y !== 8'h81) begin
      failures++;
      $display("FAIL reset_recover: got vld=%0d frm=%0d y=%02h, required 1 / 0 / 81", vld_cnt - v0, frm_cnt - f0, y);
    end
  endtask

`ifdef SER_WORD_RX_PARITY_EN
  task automatic test_parity();
    int v0;
    v0 = vld_cnt;
    ser_cs_n = 1'b0;
    wait_clks(4);
    send_word(8'h07, 1'b0, 1'b0);
    send_word(8'h07, 1'b1, 1'b1);
    ser_cs_n = 1'b1;
    wait_clks(6);
    checks++;
    if (vld_cnt - v0 !== 2 || y !== 8'h07) begin
      failures++;
      $display("FAIL parity: got vld=%0d y=%02h, required 2 / 07", vld_cnt - v0, y);
    end
  endtask
`endif

  task automatic test_idle_strobes();
    int v0, f0;
    v0 = vld_cnt;
    f0 = frm_cnt;
    ser_cs_n = 1'b1;
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    ser_cs_n = 1'b0;
    wait_clks(4);
    @(negedge clk);
    ser_dat = 1'b1;
    wait_clks(2);
    ser_clk = 1'b1;
    ser_cs_n = 1'b1;
    wait_clks(3);
    ser_clk = 1'b0;
    wait_clks(5);
    checks++;
    if (vld_cnt - v0 !== 0 || frm_cnt - f0 !== 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_strobes: got vld=%0d frm=%0d busy=%b, required 0 / 0 / 0", vld_cnt - v0, frm_cnt - f0, busy);
    end
    ser_cs_n = 1'b0;
    wait_clks(4);
    send_word(8'h42, ~^8'h42, 1'b0);
    ser_cs_n = 1'b1;
    wait_clks(6);
    checks++;
    if (vld_cnt - v0 !== 1 || y !== 8'h42) begin
      failures++;
      $display("FAIL clean_after_coincident: got vld=%0d y=%02h, required 1 / 42", vld_cnt - v0, y);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_frame_err();
    test_reset_mid();
`ifdef SER_WORD_RX_PARITY_EN
    test_parity();
`endif
    test_idle_strobes();
    wait_clks(4);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL missing_words: got %0d words outstanding, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ser_word_rx.md
# ser_word_rx

Serial-to-parallel word receiver: the capture end of the team's bit-serial register link. It samples an asynchronous three-wire input (strobe clock, frame select, data) in the local `clk` domain and synchronizes it. It assembles MSB-first words and presents each completed word on a registered parallel bus with a one-cycle valid pulse. It sits at the board-facing edge of a design, feeding control/status registers.

## Interface
- `P_NBITS`, 8 — data bits per word (≥2).
- `P_NSYNC`, 2 — synchronizer depth in flops (≥2).
- `P_DEFVAL`, 1'b0 — reset/idle value replicated across `y`.

- `clk` in 1 — local clock; all logic on posedge.
- `rst_n` in 1 — reset, asynchronous, active-low.
- `ser_clk` in 1 — remote bit strobe, asynchronous; data valid on its rising edge.
- `ser_cs_n` in 1 — remote frame select, asynchronous, active-low.
- `ser_dat` in 1 — remote serial data, asynchronous, MSB first.
- `y` out `P_NBITS` — last completed word, held until the next word completes.
- `y_vld` out 1 — one-cycle pulse when `y` updates.
- `busy` out 1 — high while in S_SHIFT with ≥1 bit collected.
- `frm_err` out 1 — one-cycle pulse when a frame ends mid-word.
- `par_err` out 1 — one-cycle pulse coincident with `y_vld` on parity mismatch; constant 0 when parity is compiled out.

## Operation
- All three serial inputs pass through identical `P_NSYNC`-deep chains, so they stay mutually aligned. `ser_clk` and `ser_cs_n` chains reset to 1; `ser_dat` resets to 0.
- Rising strobe edge: `sclk_s & ~sclk_d`, where `sclk_d` is one further register on the synced strobe.
- Bit counter width is `$clog2(P_NBITS+1)`; shift register is `P_NBITS` wide, shifting left with the new bit entering at LSB.
- FSM:
  - S_IDLE: synced cs_n high; counter 0. Synced cs_n low → S_SHIFT.
  - S_SHIFT: on each strobe edge, shift in synced `ser_dat` and increment the counter.
    - Final bit (count == `P_NBITS-1` on the edge): load `y` with the full word, pulse `y_vld`, clear counter, stay in S_SHIFT. Back-to-back words need no cs_n toggle.
    - Synced cs_n high with count 0: → S_IDLE, no error.
    - Synced cs_n high with count ≠ 0: pulse `frm_err`, discard partial word, leave `y` unchanged, → S_IDLE.
    - A strobe edge and a cs_n rise in the same cycle: the cs_n rise wins; the bit is dropped.
- Strobe edges in S_IDLE are ignored.
- Reset mid-word: all state returns to reset values immediately; the partial word is lost with no error pulse.
- Reset values: `y = {P_NBITS{P_DEFVAL}}`, `y_vld = 0`, `busy = 0`, `frm_err = 0`, `par_err = 0`, FSM in S_IDLE.

## Timing
- Input constraint: `ser_clk` high and low phases each ≥ 2 `clk` periods. `ser_dat` and `ser_cs_n` are stable ≥ 1 `clk` period before and after each `ser_clk` rising edge.
- Latency: let edge k be the first `clk` edge sampling the final `ser_clk` high. Then `y` and `y_vld` are valid in the cycle following edge k+`P_NSYNC` (cycle after k+2 at default).
- `frm_err` follows the `ser_cs_n` rise with the same latency.
- `y_vld`, `frm_err` and `par_err` are each exactly one cycle wide and are never asserted in consecutive cycles.

## Configuration
- `SER_WORD_RX_PARITY_EN` defined:
  - Each word is `P_NBITS` data bits followed by one odd-parity bit; the counter runs to `P_NBITS`.
  - `y` and `y_vld` update on the parity bit edge.
  - `par_err` pulses with `y_vld` when XOR of data bits and parity bit is 0.
  - `y` updates even on a parity error.
  - A frame ending after the data bits but before the parity bit is a `frm_err`.
- `SER_WORD_RX_PARITY_EN` undefined: `P_NBITS` bits per word, `par_err` tied 0, no parity logic.

## Structure
- Shared package `ser_pkg`: FSM state encodings (S_IDLE=0, S_SHIFT=1) and the parity-sense constant (odd).
- One sub-module, `sync_nff`: a width × depth posedge flop chain with asynchronous active-low reset and a reset-value parameter. It is instantiated three times (widths 1) or once at width 3 with per-bit reset values.

## Test plan
- Reset then `ser_cs_n` low, 8 strobes of 0xA5 → `y=8'hA5`, one-cycle `y_vld` at latency k+2, `busy` high during bits 1–7.
- Two back-to-back words 0x3C, 0xC3 with cs_n held low → two `y_vld` pulses, `y` = 0x3C then 0xC3, no `frm_err`.
- cs_n rises after 5 bits of 0xFF → single `frm_err` pulse, `y` keeps its prior value, FSM returns to S_IDLE, no `y_vld`.
- `rst_n` asserted after 3 bits, then a full 0x81 frame → `y` reads `P_DEFVAL` fill during reset, then 0x81 with no `frm_err`.
- With `SER_WORD_RX_PARITY_EN`, send 0x07 with parity 0 → `y=0x07`, `y_vld` high, `par_err` low; resend with parity 1 → `par_err` pulses with `y_vld`.
- Strobe toggles while cs_n is high, plus a strobe edge coincident with a cs_n rise → no `y_vld`, counter stays 0, no bit captured.
